lif_neuron: RTL and testbench

Leaky integrate-and-fire neuron that sits downstream of the 5-input spike MAC and consumes its 8-bit weighted sum. Each valid sum is integrated into a saturating signed membrane potential. On every timestep tick the neuron applies a shift-based leak and compares the result against a threshold. When the threshold is met it emits a one-cycle spike, clears its potential and holds off for a programmable number of ticks, producing the spike vector that the next layer's MAC receives as `pixels`.

---
 rtl/lif_neuron.sv | 113 +++++++++++
 tb/tb_lif_neuron.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating signed membrane potential, shift leak per tick,
// threshold spike with programmable refractory period. Define LIF_SPIKE_COUNT_EN to build spikeCount.
module lif_neuron #(
    parameter int IN_WIDTH     = 8,
    parameter int POT_WIDTH    = 12,
    parameter int THRESHOLD    = 100,
    parameter int LEAK_SHIFT   = 2,
    parameter int REFRAC_TICKS = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  sumIn,
    input  logic                 inValid,
    input  logic                 tick,
    output logic                 spike,
    output logic [POT_WIDTH-1:0] potential,
    output logic                 refractory,
    output logic [CNT_WIDTH-1:0] spikeCount
);

    typedef enum logic {INTEG, REFRAC} state_t;

    localparam int RC_W = (REFRAC_TICKS < 2) ? 1 : $clog2(REFRAC_TICKS + 1);
    localparam logic signed [POT_WIDTH-1:0] THRESH  = POT_WIDTH'(THRESHOLD);
    localparam logic signed [POT_WIDTH-1:0] POT_MAX = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] POT_MIN = {1'b1, {(POT_WIDTH-1){1'b0}}};

    state_t                       state_reg;
    logic signed [POT_WIDTH-1:0]  pot_reg;
    logic                         spike_reg;
    logic [RC_W-1:0]              rc_reg;

    logic signed [POT_WIDTH:0]    sum_wide;
    logic signed [POT_WIDTH-1:0]  acc;
    logic signed [POT_WIDTH-1:0]  lk;
    logic                         fire_now;

    // One guard bit above the potential makes overflow visible as a mismatch of the top two bits.
    always_comb begin
        sum_wide = {pot_reg[POT_WIDTH-1], pot_reg}
                 + {{(POT_WIDTH+1-IN_WIDTH){sumIn[IN_WIDTH-1]}}, sumIn};
        acc = pot_reg;
        if (inValid) begin
            if (sum_wide[POT_WIDTH] != sum_wide[POT_WIDTH-1])
                acc = sum_wide[POT_WIDTH] ? POT_MIN : POT_MAX;
            else
                acc = sum_wide[POT_WIDTH-1:0];
        end
        if (LEAK_SHIFT == 0)
            lk = acc;
        else
            lk = acc - (acc >>> LEAK_SHIFT);
        fire_now = (state_reg == INTEG) && tick && (lk >= THRESH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= INTEG;
            pot_reg   <= '0;
            spike_reg <= 1'b0;
            rc_reg    <= '0;
        end else begin
            spike_reg <= 1'b0;
            case (state_reg)
                INTEG: begin
                    if (fire_now) begin
                        spike_reg <= 1'b1;
                        pot_reg   <= '0;
                        if (REFRAC_TICKS > 0) begin
                            state_reg <= REFRAC;
                            rc_reg    <= RC_W'(REFRAC_TICKS);
                        end
                    end else if (tick) begin
                        pot_reg <= lk;
                    end else begin
                        pot_reg <= acc;
                    end
                end
                REFRAC: begin
                    // Input is ignored while refractory; only ticks advance the hold-off.
                    pot_reg <= '0;
                    if (tick) begin
                        rc_reg <= rc_reg - 1'b1;
                        if (rc_reg == RC_W'(1))
                            state_reg <= INTEG;
                    end
                end
                default: state_reg <= INTEG;
            endcase
        end
    end

    assign spike      = spike_reg;
    assign potential  = pot_reg;
    assign refractory = (state_reg == REFRAC);

`ifdef LIF_SPIKE_COUNT_EN
    logic [CNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst)
            count_reg <= '0;
        else if (fire_now && (count_reg != {CNT_WIDTH{1'b1}}))
            count_reg <= count_reg + 1'b1;
    end

    assign spikeCount = count_reg;
`else
    assign spikeCount = '0;
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// Directed-vector bench for lif_neuron with default parameters; expected values hand-computed.
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sumIn;
    logic        inValid;
    logic        tick;
    logic        spike;
    logic [11:0] potential;
    logic        refractory;
    logic [15:0] spikeCount;

    int chk_cnt  = 0;
    int pass_cnt = 0;

`ifdef LIF_SPIKE_COUNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    lif_neuron dut (
        .clk        (clk),
        .rst        (rst),
        .sumIn      (sumIn),
        .inValid    (inValid),
        .tick       (tick),
        .spike      (spike),
        .potential  (potential),
        .refractory (refractory),
        .spikeCount (spikeCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else begin
            pass_cnt++;
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [31:0] pot();
        logic signed [11:0] p;
        p = potential;
        return p;
    endfunction

    task automatic drive(input logic r, input logic v, input int s, input logic t);
        rst     = r;
        inValid = v;
        sumIn   = s[7:0];
        tick    = t;
    endtask

    initial begin
        drive(1, 1, 50, 0);
        // Reset held two cycles with live input
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_pot",   pot(), 0);
            check("rst_spike", spike, 0);
            check("rst_refr",  refractory, 0);
            check("rst_cnt",   spikeCount, 0);
        end
        drive(0, 0, 0, 0);
        step();
        check("post_rst_pot", pot(), 0);

        // Integrate 3 x 40, then leak 120 -> 90
        drive(0, 1, 40, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("integ_pot", pot(), 40 * i);
        end
        drive(0, 0, 0, 1);
        step();
        check("leak_pot",   pot(), 90);
        check("leak_spike", spike, 0);

        // Fire: 90 + 50 = 140, leak -> 105 >= 100
        drive(0, 1, 50, 1);
        step();
        check("fire_spike", spike, 1);
        check("fire_pot",   pot(), 0);
        check("fire_refr",  refractory, 1);
        check("fire_cnt",   spikeCount, CNT_ON);

        // Refractory: input discarded, two ticks to leave
        drive(0, 1, 127, 0);
        step();
        check("refr_spike_low", spike, 0);
        check("refr_pot0",      pot(), 0);
        check("refr_hold",      refractory, 1);
        drive(0, 1, 127, 1);
        step();
        check("refr_tick1", refractory, 1);
        check("refr_pot1",  pot(), 0);
        drive(0, 1, 127, 0);
        step();
        check("refr_pot2",  pot(), 0);
        drive(0, 1, 127, 1);
        step();
        check("refr_tick2", refractory, 0);
        check("refr_last_pot", pot(), 0);
        check("refr_last_spike", spike, 0);
        drive(0, 1, 10, 0);
        step();
        check("post_refr_pot", pot(), 10);
        check("post_refr_cnt", spikeCount, CNT_ON);

        // Positive saturation
        drive(0, 1, 127, 0);
        for (int i = 0; i < 20; i++) step();
        check("sat_pos", pot(), 2047);

        // Negative saturation and leak toward zero
        drive(1, 0, 0, 0);
        step();
        check("rst2_pot", pot(), 0);
        check("rst2_cnt", spikeCount, 0);
        drive(0, 1, -128, 0);
        for (int i = 0; i < 20; i++) step();
        check("sat_neg", pot(), -2048);
        drive(0, 0, 0, 1);
        step();
        check("neg_leak",  pot(), -1536);
        check("neg_spike", spike, 0);

        // -8 leaks to -6
        drive(1, 0, 0, 0);
        step();
        drive(0, 1, -8, 0);
        step();
        drive(0, 0, 0, 1);
        step();
        check("neg8_leak", pot(), -6);

        // Threshold boundary: 132 -> 99 (no fire)
        drive(1, 0, 0, 0);
        step();
        drive(0, 1, 127, 0);
        step();
        drive(0, 1, 5, 1);
        step();
        check("thr_below_pot",   pot(), 99);
        check("thr_below_spike", spike, 0);

        // 133 -> exactly 100 fires
        drive(1, 0, 0, 0);
        step();
        drive(0, 1, 127, 0);
        step();
        drive(0, 1, 6, 1);
        step();
        check("thr_eq_spike", spike, 1);
        check("thr_eq_refr",  refractory, 1);
        check("thr_eq_cnt",   spikeCount, CNT_ON);

        // Reset mid-refractory
        drive(1, 1, 127, 1);
        step();
        check("rst_mid_refr",  refractory, 0);
        check("rst_mid_cnt",   spikeCount, 0);
        check("rst_mid_spike", spike, 0);
        check("rst_mid_pot",   pot(), 0);
        drive(0, 1, 5, 0);
        step();
        check("post_mid_pot",  pot(), 5);
        check("post_mid_refr", refractory, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
